// File: rtl/config_pkg.sv
// Global configuration record shared by backend units.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{XLEN: 32};

endpackage

// File: rtl/csr_pkg.sv
// CSR addresses, mstatus layout, CSR unit FSM states and the held-write record.
package csr_pkg;

  localparam logic [11:0] CsrSatp      = 12'h180;
  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMtval     = 12'h343;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMhartid   = 12'hF14;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;
  localparam logic [63:0] MstatusWmask = 64'h0000_0000_0000_1888;

  typedef enum logic {IDLE, PENDING} csr_state_e;

  // Sized for the widest supported XLEN / tag; users slice down.
  typedef struct packed {
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [15:0] tag;
  } pend_wr_t;

endpackage

// File: rtl/decode_pkg.sv
// Decoded micro-op format as seen by the execute-stage units.
package decode_pkg;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } csr_op_e;

  typedef struct packed {
    logic        is_csr;
    csr_op_e     csr_op;
    logic [11:0] csr_addr;
    logic [31:0] imm;
  } uop_t;

endpackage

// File: rtl/csr_counters.sv
// 64-bit mcycle/minstret counters with committed-write override of the increment.
module csr_counters
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      instret_inc_i,
  input  logic            wr_en_i,
  input  logic [11:0]     wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic [63:0]     mcycle_o,
  output logic [63:0]     minstret_o
);

  logic [63:0] wd;
  logic [63:0] cyc_d;
  logic [63:0] ret_d;

  assign wd = 64'(wr_data_i);

  // On RV32 a write touches only the addressed half of the 64-bit counter.
  function automatic logic [63:0] merge(input logic [63:0] cur, input logic [63:0] w,
                                        input logic hi);
    if (XLEN >= 64) return w;
    else if (hi) return {w[31:0], cur[31:0]};
    else return {cur[63:32], w[31:0]};
  endfunction

  always_comb begin
    cyc_d = mcycle_o + 64'd1;
    ret_d = minstret_o + 64'(instret_inc_i);
    if (wr_en_i) begin
      case (wr_addr_i)
        CsrMcycle:    cyc_d = merge(mcycle_o, wd, 1'b0);
        CsrMinstret:  ret_d = merge(minstret_o, wd, 1'b0);
        CsrMcycleh:   if (XLEN == 32) cyc_d = merge(mcycle_o, wd, 1'b1);
        CsrMinstreth: if (XLEN == 32) ret_d = merge(minstret_o, wd, 1'b1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcycle_o   <= '0;
      minstret_o <= '0;
    end else begin
      mcycle_o   <= cyc_d;
      minstret_o <= ret_d;
    end
  end

endmodule

// File: rtl/execute_csr_commit.sv
// Machine-mode CSR unit: reads at execute, holds the write until ROB commit.
// Optional counters (mcycle/minstret) enabled by defining CSR_COUNTERS_EN.
module execute_csr_commit
  import csr_pkg::*;
  import decode_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg         = config_pkg::EmptyCfg,
  parameter int unsigned      XLEN        = Cfg.XLEN,
  parameter int unsigned      TAG_W       = 6,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
  parameter int unsigned      HART_ID     = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  decode_pkg::uop_t  uop_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [TAG_W-1:0]  rob_tag_i,
  output logic              resp_valid_o,
  output logic [TAG_W-1:0]  resp_rob_tag_o,
  output logic [XLEN-1:0]   resp_result_o,
  output logic              resp_illegal_o,
  input  logic              commit_valid_i,
  input  logic [TAG_W-1:0]  commit_rob_tag_i,
  input  logic              flush_i,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  input  logic [XLEN-1:0]   trap_tval_i,
  input  logic              mret_i,
  output logic [XLEN-1:0]   trap_target_o,
  output logic [XLEN-1:0]   mret_target_o,
  input  logic [1:0]        instret_inc_i
);

  csr_state_e      state_q, state_d;
  pend_wr_t        pend_q;
  logic [XLEN-1:0] src, old_val, new_val, wdata;
  logic            impl, wen, illegal, accept, take_pend, commit_hit, commit_we;
  logic            st_mie_q, st_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, satp_q;
  logic            unused_bits;

  assign wdata       = pend_q.wdata[XLEN-1:0];
  assign unused_bits = ^{pend_q, uop_i.imm, trap_pc_i[1:0], mtvec_q[1:0]};

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counters #(.XLEN(XLEN)) u_counters (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instret_inc_i (instret_inc_i),
    .wr_en_i       (commit_we),
    .wr_addr_i     (pend_q.addr),
    .wr_data_i     (wdata),
    .mcycle_o      (mcycle),
    .minstret_o    (minstret)
  );
`else
  logic unused_inc;
  assign unused_inc = ^instret_inc_i;
`endif

  assign src = (uop_i.csr_op inside {CSRRWI, CSRRSI, CSRRCI}) ? XLEN'(uop_i.imm[4:0]) : rs1_data_i;

  always_comb begin
    impl    = 1'b1;
    old_val = '0;
    case (uop_i.csr_addr)
      CsrMstatus: begin
        old_val[MstatusMppHi:MstatusMppLo] = 2'b11;
        old_val[MstatusMpie]               = st_mpie_q;
        old_val[MstatusMie]                = st_mie_q;
      end
      CsrMie:      old_val = mie_q;
      CsrMtvec:    old_val = mtvec_q;
      CsrMscratch: old_val = mscratch_q;
      CsrMepc:     old_val = mepc_q;
      CsrMcause:   old_val = mcause_q;
      CsrMtval:    old_val = mtval_q;
      CsrSatp:     old_val = satp_q;
      CsrMip:      old_val = '0;
      CsrMhartid:  old_val = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      CsrMcycle:    old_val = XLEN'(mcycle);
      CsrMinstret:  old_val = XLEN'(minstret);
      CsrMcycleh:   if (XLEN == 32) old_val = XLEN'(mcycle >> 32); else impl = 1'b0;
      CsrMinstreth: if (XLEN == 32) old_val = XLEN'(minstret >> 32); else impl = 1'b0;
`endif
      default:     impl = 1'b0;
    endcase
  end

  always_comb begin
    wen     = 1'b0;
    new_val = old_val;
    case (uop_i.csr_op)
      CSRRW, CSRRWI: begin wen = 1'b1; new_val = src;            end
      CSRRS, CSRRSI: begin wen = |src; new_val = old_val | src;  end
      CSRRC, CSRRCI: begin wen = |src; new_val = old_val & ~src; end
      default: ;
    endcase
  end

  assign illegal    = !impl || (wen && uop_i.csr_addr[11:10] == 2'b11);
  assign accept     = req_valid_i && uop_i.is_csr && req_ready_o;
  assign take_pend  = accept && !illegal && wen && !flush_i && !trap_valid_i;
  assign commit_hit = commit_valid_i && (commit_rob_tag_i == pend_q.tag[TAG_W-1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_pend) state_d = PENDING;
      PENDING: if (flush_i || trap_valid_i || commit_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    commit_we   = (state_q == PENDING) && commit_hit && !flush_i && !trap_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else if (take_pend) begin
      pend_q <= '{addr: uop_i.csr_addr, wdata: 64'(new_val), tag: 16'(rob_tag_i)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_o   <= 1'b0;
      resp_rob_tag_o <= '0;
      resp_result_o  <= '0;
      resp_illegal_o <= 1'b0;
    end else begin
      resp_valid_o <= accept && !flush_i;
      if (accept) begin
        resp_rob_tag_o <= rob_tag_i;
        resp_result_o  <= old_val;
        resp_illegal_o <= illegal;
      end
    end
  end

  // Later assignments win: trap overrides mret, which overrides a committed write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      satp_q     <= '0;
    end else begin
      if (commit_we) begin
        case (pend_q.addr)
          CsrMstatus: begin
            st_mie_q  <= wdata[MstatusMie];
            st_mpie_q <= wdata[MstatusMpie];
          end
          CsrMie:      mie_q      <= wdata;
          CsrMtvec:    mtvec_q    <= wdata;
          CsrMscratch: mscratch_q <= wdata;
          CsrMepc:     mepc_q     <= wdata;
          CsrMcause:   mcause_q   <= wdata;
          CsrMtval:    mtval_q    <= wdata;
          CsrSatp:     satp_q     <= wdata;
          default: ;
        endcase
      end
      if (mret_i) begin
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
      end
      if (trap_valid_i) begin
        mepc_q    <= {trap_pc_i[XLEN-1:2], 2'b00};
        mcause_q  <= trap_cause_i;
        mtval_q   <= trap_tval_i;
        st_mpie_q <= st_mie_q;
        st_mie_q  <= 1'b0;
      end
    end
  end

  assign trap_target_o = {mtvec_q[XLEN-1:2], 2'b00};
  assign mret_target_o = mepc_q;

endmodule

// File: tb/tb_execute_csr_commit.sv
// Randomized bench for execute_csr_commit against a CSR-map reference model.
module tb_execute_csr_commit;
  import decode_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 6;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MSCR = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342;
  localparam logic [11:0] A_MTVAL = 12'h343, A_MIP = 12'h344, A_SATP = 12'h180;
  localparam logic [11:0] A_MHART = 12'hF14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  uop_t              uop;
  logic [XLEN-1:0]   rs1_data;
  logic [TAG_W-1:0]  rob_tag;
  logic              resp_valid, resp_illegal;
  logic [TAG_W-1:0]  resp_tag;
  logic [XLEN-1:0]   resp_result;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic              flush, trap_valid, mret;
  logic [XLEN-1:0]   trap_pc, trap_cause, trap_tval, trap_target, mret_target;
  logic [1:0]        instret_inc;

  execute_csr_commit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .uop_i(uop), .rs1_data_i(rs1_data), .rob_tag_i(rob_tag),
    .resp_valid_o(resp_valid), .resp_rob_tag_o(resp_tag),
    .resp_result_o(resp_result), .resp_illegal_o(resp_illegal),
    .commit_valid_i(commit_valid), .commit_rob_tag_i(commit_tag),
    .flush_i(flush), .trap_valid_i(trap_valid),
    .trap_pc_i(trap_pc), .trap_cause_i(trap_cause), .trap_tval_i(trap_tval),
    .mret_i(mret), .trap_target_o(trap_target), .mret_target_o(mret_target),
    .instret_inc_i(instret_inc)
  );

  always #5 clk = ~clk;

  // Reference model: architectural CSR map plus at most one held write.
  logic [XLEN-1:0]  mdl [logic [11:0]];
  bit               pend;
  logic [11:0]      p_addr;
  logic [XLEN-1:0]  p_val;
  logic [TAG_W-1:0] p_tag;
  logic [XLEN-1:0]  last_res;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    logic [11:0] impl_list[$];
    impl_list = {A_MSTATUS, A_MIE, A_MTVEC, A_MSCR, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP, A_SATP, A_MHART};
    mdl.delete();
    foreach (impl_list[i]) mdl[impl_list[i]] = '0;
    mdl[A_MSTATUS] = 32'h1800;
    pend = 0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [XLEN-1:0] v);
    if (a == A_MSTATUS) mdl[a] = 32'h1800 | (v & 32'h88);
    else if (a != A_MIP && a != A_MHART) mdl[a] = v;
  endtask

  task automatic check_state(input string nm);
    check({nm, "_ready"}, req_ready, !pend);
    check({nm, "_trap_tgt"}, trap_target, mdl[A_MTVEC] & ~32'h3);
    check({nm, "_mret_tgt"}, mret_target, mdl[A_MEPC]);
  endtask

  task automatic issue(input csr_op_e op, input logic [11:0] a, input logic [XLEN-1:0] rs1,
                       input logic [4:0] imm, input logic [TAG_W-1:0] tag, input bit fl);
    logic [XLEN-1:0] s, old, nv;
    bit legal, wr, ill;
    legal = mdl.exists(a);
    old   = legal ? mdl[a] : '0;
    s     = (op inside {CSRRWI, CSRRSI, CSRRCI}) ? XLEN'(imm) : rs1;
    wr    = (op inside {CSRRW, CSRRWI}) || (s != 0);
    case (op)
      CSRRW, CSRRWI: nv = s;
      CSRRS, CSRRSI: nv = old | s;
      default:       nv = old & ~s;
    endcase
    ill = !legal || (wr && a[11:10] == 2'b11);
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    uop       = '{is_csr: 1'b1, csr_op: op, csr_addr: a, imm: 32'(imm)};
    rs1_data  = rs1;
    rob_tag   = tag;
    flush     = fl;
    tick;
    req_valid = 1'b0;
    flush     = 1'b0;
    if (fl) begin
      check("resp_flushed", resp_valid, 0);
    end else begin
      check("resp_valid", resp_valid, 1);
      check("resp_tag", resp_tag, tag);
      check("resp_illegal", resp_illegal, ill);
      if (legal) check("resp_result", resp_result, old);
      last_res = resp_result;
    end
    if (!ill && wr && !fl) begin
      pend = 1; p_addr = a; p_val = nv; p_tag = tag;
    end
    check("ready_after_req", req_ready, !pend);
  endtask

  task automatic cycle(input bit cv, input logic [TAG_W-1:0] ct, input bit fl, input bit tr,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause,
                       input logic [XLEN-1:0] tval, input bit mr);
    logic [XLEN-1:0] ms0;
    commit_valid = cv; commit_tag = ct; flush = fl; trap_valid = tr;
    trap_pc = pc; trap_cause = cause; trap_tval = tval; mret = mr;
    tick;
    commit_valid = 0; flush = 0; trap_valid = 0; mret = 0;
    ms0 = mdl[A_MSTATUS];
    if (pend) begin
      if (fl || tr) pend = 0;
      else if (cv && ct == p_tag) begin
        model_write(p_addr, p_val);
        pend = 0;
      end
    end
    if (tr) begin
      mdl[A_MEPC]    = pc & ~32'h3;
      mdl[A_MCAUSE]  = cause;
      mdl[A_MTVAL]   = tval;
      mdl[A_MSTATUS] = 32'h1800 | (XLEN'(ms0[3]) << 7);
    end else if (mr) begin
      mdl[A_MSTATUS] = 32'h1880 | (XLEN'(ms0[7]) << 3);
    end
    check("resp_quiet", resp_valid, 0);
    check_state("cyc");
  endtask

  task automatic rd(input logic [11:0] a, input logic [XLEN-1:0] exp, input string nm);
    issue(CSRRS, a, '0, 5'd0, TAG_W'(n_checks), 1'b0);
    check(nm, last_res, exp);
  endtask

  initial begin
    logic [11:0] alist[$];
    csr_op_e     ops[$];
    logic [TAG_W-1:0] t;
    int act;

    rst_n = 0; req_valid = 0; uop = '0; rs1_data = '0; rob_tag = '0;
    commit_valid = 0; commit_tag = '0; flush = 0; trap_valid = 0; mret = 0;
    trap_pc = '0; trap_cause = '0; trap_tval = '0; instret_inc = '0;
    model_reset();
    tick; tick;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_illegal", resp_illegal, 0);
    check_state("rst");
    rst_n = 1;
    tick;

    issue(CSRRW, A_MSCR, 32'h55, 5'd0, 6'd3, 1'b0);
    check("mscratch_old", last_res, 0);
    cycle(1, 6'd3, 0, 0, '0, '0, '0, 0);
    rd(A_MSCR, 32'h55, "mscratch_new");

    issue(CSRRS, A_MTVEC, '0, 5'd0, 6'd4, 1'b0);
    check("csrrs_x0_idle", req_ready, 1);

    issue(CSRRW, A_MEPC, 32'h80, 5'd0, 6'd5, 1'b0);
    cycle(0, '0, 1, 0, '0, '0, '0, 0);
    rd(A_MEPC, 32'h0, "mepc_after_flush");

    issue(CSRRW, A_MHART, 32'h1, 5'd0, 6'd6, 1'b0);
    check("mhartid_illegal", resp_illegal, 1);
    issue(CSRRW, 12'h7C0, 32'h1, 5'd0, 6'd7, 1'b0);
    check("unimpl_illegal", resp_illegal, 1);
    rd(A_MHART, 32'h0, "mhartid_value");

    issue(CSRRSI, A_MSTATUS, '0, 5'd8, 6'd8, 1'b0);
    cycle(1, 6'd8, 0, 0, '0, '0, '0, 0);
    cycle(0, '0, 0, 1, 32'h1002, 32'd2, 32'h0, 0);
    rd(A_MEPC, 32'h1000, "trap_mepc");
    rd(A_MCAUSE, 32'd2, "trap_mcause");
    rd(A_MSTATUS, 32'h1880, "trap_mstatus");
    cycle(0, '0, 0, 0, '0, '0, '0, 1);
    rd(A_MSTATUS, 32'h1888, "mret_mstatus");

    issue(CSRRW, A_MSCR, 32'h77, 5'd0, 6'd9, 1'b1);
    check("flush_at_accept_ready", req_ready, 1);

    issue(CSRRW, A_MSCR, 32'h77, 5'd0, 6'd9, 1'b0);
    rst_n = 0;
    #2;
    check("rst_mid_pending_ready", req_ready, 1);
    tick;
    rst_n = 1;
    model_reset();
    cycle(1, 6'd9, 0, 0, '0, '0, '0, 0);
    rd(A_MSCR, 32'h0, "rst_drops_write");

`ifdef CSR_COUNTERS_EN
    rst_n = 0;
    tick; tick;
    rst_n = 1;
    model_reset();
    repeat (10) tick;
    mdl[12'hB00] = 32'd10;
    rd(12'hB00, 32'd10, "mcycle_10");
    mdl.delete(12'hB00);
    instret_inc = 2'd2;
    repeat (3) tick;
    instret_inc = 2'd0;
    mdl[12'hB02] = 32'd6;
    rd(12'hB02, 32'd6, "minstret_6");
    mdl.delete(12'hB02);
`endif

    alist = {A_MSTATUS, A_MIE, A_MTVEC, A_MSCR, A_MEPC, A_MCAUSE, A_MTVAL, A_SATP,
             A_MIP, A_MHART, 12'h7C0, 12'h301};
`ifndef CSR_COUNTERS_EN
    alist.push_back(12'hB00);
`endif
    ops = {CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};

    for (int i = 0; i < 250; i++) begin
      issue(ops[$urandom_range(0, ops.size() - 1)],
            alist[$urandom_range(0, alist.size() - 1)],
            ($urandom_range(0, 3) == 0) ? '0 : XLEN'($urandom),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            TAG_W'($urandom),
            $urandom_range(0, 15) == 0);
      if (pend) begin
        act = $urandom_range(0, 4);
        case (act)
          0: cycle(1, p_tag, 0, 0, '0, '0, '0, 0);
          1: begin
            t = p_tag ^ TAG_W'($urandom_range(1, 63));
            cycle(1, t, 0, 0, '0, '0, '0, 0);
            cycle(1, p_tag, 0, 0, '0, '0, '0, 0);
          end
          2: cycle(0, '0, 1, 0, '0, '0, '0, 0);
          3: cycle(1, p_tag, 0, 1, XLEN'($urandom), XLEN'($urandom), XLEN'($urandom), 0);
          default: cycle(1, p_tag, 1, 0, '0, '0, '0, 0);
        endcase
      end else if ($urandom_range(0, 3) == 0) begin
        act = $urandom_range(0, 1);
        cycle(0, '0, 0, act[0], XLEN'($urandom), XLEN'($urandom), XLEN'($urandom), !act[0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_csr_commit.md
# execute_csr_commit

Parametrised machine-mode CSR unit for the out-of-order backend: executes CSR uops, returns the old value to the ROB, and holds the architectural write until the owning ROB entry commits. A flush discards the held write. The unit also applies trap entry and `mret` state changes. It sits beside the ALU/BRU in the execute stage and drives trap and return targets to the frontend redirect logic.

## Interface
- `Cfg`, default `config_pkg::EmptyCfg`: global configuration.
- `XLEN`, default `Cfg.XLEN`: data width, 32 or 64.
- `TAG_W`, default 6: ROB tag width.
- `MTVEC_RESET`, default `'0`: reset value of `mtvec`.
- `HART_ID`, default 0: value returned by `mhartid`.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: CSR uop offered.
- `req_ready_o` out 1: unit can accept a uop.
- `uop_i` in `decode_pkg::uop_t`: uses `is_csr`, `csr_op`, `csr_addr`, `imm[4:0]`.
- `rs1_data_i` in XLEN: register source operand.
- `rob_tag_i` in TAG_W: ROB tag of the uop.
- `resp_valid_o` out 1: result valid, one-cycle pulse.
- `resp_rob_tag_o` out TAG_W: tag of the result.
- `resp_result_o` out XLEN: old CSR value.
- `resp_illegal_o` out 1: access is illegal; the ROB raises an exception.
- `commit_valid_i` in 1: the ROB head is committing.
- `commit_rob_tag_i` in TAG_W: tag of the committing entry.
- `flush_i` in 1: pipeline flush.
- `trap_valid_i` in 1: take a trap this cycle.
- `trap_pc_i` in XLEN: faulting PC.
- `trap_cause_i` in XLEN: cause value.
- `trap_tval_i` in XLEN: trap value.
- `mret_i` in 1: `mret` commits this cycle.
- `trap_target_o` out XLEN: `{mtvec[XLEN-1:2],2'b00}`, combinational.
- `mret_target_o` out XLEN: `mepc`, combinational.
- `instret_inc_i` in 2: instructions retired this cycle; used only when `CSR_COUNTERS_EN` is defined.

## Operation
- Implemented CSRs:
  - Read/write: `mstatus` (0x300), `mie` (0x304), `mtvec` (0x305), `mscratch` (0x340), `mepc` (0x341), `mcause` (0x342), `mtval` (0x343), `satp` (0x180).
  - Read-only: `mip` (0x344, reads 0), `mhartid` (0xF14).
- `mstatus` write mask is MIE[3], MPIE[7], MPP[12:11]. MPP always reads 2'b11. Reset value is 0x1800.
- Source operand is `imm[4:0]` zero-extended for `*I` ops, otherwise `rs1_data_i`.
- Write enable:
  - RW/RWI always write.
  - RS/RC/RSI/RCI write only when the source is nonzero.
- New value by op:
  - RW: source.
  - RS: old | source.
  - RC: old & ~source.
- An access is illegal if either:
  - the address is unimplemented, or
  - a write is enabled and `csr_addr[11:10]==2'b11`.
- FSM `IDLE`:
  - `req_ready_o=1`.
  - Accept on `req_valid_i && uop_i.is_csr`.
  - If the access is legal and writes: latch {addr, new value, tag} and go to `PENDING`.
  - Otherwise stay in `IDLE`.
- FSM `PENDING`:
  - `req_ready_o=0`.
  - On `commit_valid_i && commit_rob_tag_i==held tag`: write the CSR and go to `IDLE`.
  - A non-matching commit tag is ignored.
  - `flush_i` or `trap_valid_i` discards the held write and goes to `IDLE`. These win over a same-cycle commit.
- Trap entry: `mepc<=trap_pc_i` with bits [1:0] cleared, `mcause<=trap_cause_i`, `mtval<=trap_tval_i`, MPIE<=MIE, MIE<=0.
- `mret`: MIE<=MPIE, MPIE<=1.
- Priority when events coincide: trap > mret > committed write.

## Timing
- Reset values:
  - Outputs: all `resp_*` are 0; `req_ready_o=1`.
  - Registers: FSM is `IDLE`; all CSRs are 0 except `mstatus=0x1800` and `mtvec=MTVEC_RESET`.
- Response latency is one cycle. A uop accepted at edge T has `resp_*` valid in cycle T+1.
- Responses are registered and never stall.
- Reads return committed state only. Writes are serialised, so there is no forwarding.
- A commit at edge C has its CSR value visible from cycle C+1. `req_ready_o` reasserts in cycle C+1.
- A commit may arrive in the same cycle as `resp_valid_o`.
- `flush_i` also clears a `resp_valid_o` that would launch at that edge.
- Reset asserted mid-`PENDING` drops the held write.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - Adds `mcycle` (0xB00) and `minstret` (0xB02), both 64-bit.
  - For XLEN=32, also adds `mcycleh` (0xB80) and `minstreth` (0xB82).
  - `mcycle` increments every cycle; `minstret` increments by `instret_inc_i`.
  - A committed write to a counter overrides that cycle's increment.
- `CSR_COUNTERS_EN` undefined: these addresses are illegal and `instret_inc_i` is ignored.

## Structure
- New `csr_pkg` holds:
  - CSR address localparams.
  - `mstatus` bit indices and write mask.
  - `csr_state_e {IDLE, PENDING}`.
  - The pending-write struct `{addr, wdata, tag}`.
- Sub-module `csr_counters` holds the counter registers, increment and override logic. It is instantiated only under `CSR_COUNTERS_EN`.

## Test plan
- `csrrw mscratch, 0x55`, then commit the matching tag → response returns 0. A following `csrr` returns 0x55.
- `csrrs mtvec, x0` → `resp_valid_o` next cycle, stays in `IDLE`, `req_ready_o` stays 1.
- `csrrw mepc, 0x80` followed by `flush_i` while `PENDING` → `mepc` remains 0 and ready reasserts the next cycle.
- `csrrw` to 0xF14, or to 0x7C0 → `resp_illegal_o=1` and no state change.
- Trap with pc 0x1002 and cause 2 while MIE=1 → `mepc=0x1000`, `mcause=2`, MIE=0, MPIE=1. A following `mret` → MIE=1.
- With `CSR_COUNTERS_EN`: hold reset low, release, wait 10 cycles, read `mcycle` → 10. `instret_inc_i=2` for 3 cycles → `minstret=6`.
